// File: rtl/mss_pkg.sv
// Shared types and defaults for the mss_block scan-access controller.
// The MSS_SCAN_PARITY_EN build option is handled in mss_scan_ctrl.
package mss_pkg;

    localparam int CHAIN_LEN_DEF = 8;
    localparam int NUM_REQ_DEF   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } mss_state_e;

    // A single requester still needs a one-bit id field.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mss_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr,
// wrapping. The pointer register is owned by the caller.
module mss_rr_arbiter
    import mss_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id
);

    int   idx;
    logic found;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mss_scan_ctrl.sv
// Scan-access controller for one mss_block chain shared by NUM_REQ requesters.
// Build option MSS_SCAN_PARITY_EN adds rsp_parity (XOR of the captured bits).
module mss_scan_ctrl
    import mss_pkg::*;
#(
    parameter int CHAIN_LEN = CHAIN_LEN_DEF,
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int ID_W      = id_w(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*CHAIN_LEN-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [CHAIN_LEN-1:0]         rsp_data,
    output logic [ID_W-1:0]              rsp_id,
    output logic                         busy,
    output logic                         mss_enable,
    output logic                         mss_scan_in,
    output logic [ID_W-1:0]              mss_cluster_sel,
    input  logic                         mss_scan_out,
`ifdef MSS_SCAN_PARITY_EN
    output logic                         rsp_parity,
`endif
    output mss_state_e                   dbg_state
);

    localparam int                CNT_W    = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [ID_W-1:0]   LAST_ID  = ID_W'(NUM_REQ - 1);

    mss_state_e           state;
    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      gnt_id;
    logic [NUM_REQ-1:0]   gnt;
    logic [CHAIN_LEN-1:0] pat_q;
    logic [CHAIN_LEN-1:0] cap_q;
    logic [CHAIN_LEN-1:0] cap_next;
    logic [CHAIN_LEN-1:0] gnt_data;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 accept;

    mss_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req      (req_valid),
        .ptr      (rr_ptr),
        .grant    (gnt),
        .grant_id (gnt_id)
    );

    // Handshakes: a transfer happens on a clock edge where valid and ready are
    // both high; rsp_* stay stable while rsp_valid is high and rsp_ready is low.
    assign req_ready = (state == IDLE) ? gnt : '0;
    assign accept    = (state == IDLE) && (|gnt);
    assign gnt_data  = req_data[gnt_id*CHAIN_LEN +: CHAIN_LEN];
    assign cap_next  = {cap_q[CHAIN_LEN-2:0], mss_scan_out};

    // pat_q drains to zero during SHIFT, so scan_in is quiet outside it.
    assign mss_scan_in = pat_q[CHAIN_LEN-1];
    assign dbg_state   = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            rr_ptr          <= '0;
            pat_q           <= '0;
            cap_q           <= '0;
            bit_cnt         <= '0;
            rsp_valid       <= 1'b0;
            rsp_data        <= '0;
            rsp_id          <= '0;
            busy            <= 1'b0;
            mss_enable      <= 1'b0;
            mss_cluster_sel <= '0;
`ifdef MSS_SCAN_PARITY_EN
            rsp_parity      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        pat_q           <= gnt_data;
                        cap_q           <= '0;
                        bit_cnt         <= '0;
                        rr_ptr          <= (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
                        mss_cluster_sel <= gnt_id;
                        mss_enable      <= 1'b1;
                        busy            <= 1'b1;
                        state           <= SHIFT;
                    end
                end
                SHIFT: begin
                    pat_q   <= pat_q << 1;
                    cap_q   <= cap_next;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        mss_enable <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_data   <= cap_next;
                        rsp_id     <= mss_cluster_sel;
`ifdef MSS_SCAN_PARITY_EN
                        rsp_parity <= ^cap_next;
`endif
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mss_scan_ctrl.sv
// Directed bench for mss_scan_ctrl with a behavioural mss_block chain attached.
// Honours MSS_SCAN_PARITY_EN for the rsp_parity port.
module tb_mss_scan_ctrl;
    import mss_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_id;
    logic        busy;
    logic        mss_enable;
    logic        mss_scan_in;
    logic [1:0]  mss_cluster_sel;
    logic        mss_scan_out;
`ifdef MSS_SCAN_PARITY_EN
    logic        rsp_parity;
`endif
    mss_state_e  dbg_state;

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];
    logic [9:0] mon_exp;

    always #5 clk = ~clk;

    mss_scan_ctrl #(.CHAIN_LEN(8), .NUM_REQ(4)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .rsp_id          (rsp_id),
        .busy            (busy),
        .mss_enable      (mss_enable),
        .mss_scan_in     (mss_scan_in),
        .mss_cluster_sel (mss_cluster_sel),
        .mss_scan_out    (mss_scan_out),
`ifdef MSS_SCAN_PARITY_EN
        .rsp_parity      (rsp_parity),
`endif
        .dbg_state       (dbg_state)
    );

    // Behavioural mss_block chain; deliberately not reset with the controller.
    logic [7:0] chain = 8'h00;
    assign mss_scan_out = chain[7];
    always @(posedge clk) if (mss_enable) chain <= {chain[6:0], mss_scan_in};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [7:0] pat);
        req_valid[r]         = 1'b1;
        req_data[r*8 +: 8]   = pat;
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [7:0] data);
        exp_q.push_back({id, data});
    endtask

    // Waits for a grant, checks its id, and returns just after the accepting edge.
    task automatic wait_accept(input string name, input int exp_id);
        int got;
        got = -1;
        for (int n = 0; n < 100 && got < 0; n++) begin
            @(negedge clk);
            if ((req_valid & req_ready) != 4'b0) begin
                for (int i = 0; i < 4; i++) if (req_ready[i]) got = i;
                check({name, "_onehot"}, 32'($onehot(req_ready)), 1);
            end
        end
        if (got < 0) begin
            checks++;
            errors++;
            $display("FAIL %s: no grant within 100 cycles, expected id %0d", name, exp_id);
        end else begin
            check(name, got, exp_id);
        end
        step();
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s: busy still high after 100 cycles, expected 0", name);
        end
    endtask

    task automatic do_reset();
        step();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_data"}, rsp_data, 0);
        check({tag, "_rsp_id"}, rsp_id, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_mss_enable"}, mss_enable, 0);
        check({tag, "_mss_scan_in"}, mss_scan_in, 0);
        check({tag, "_cluster_sel"}, mss_cluster_sel, 0);
        check({tag, "_state"}, dbg_state, IDLE);
    endtask

    // Response monitor: pops the scoreboard on every response handshake.
    always @(negedge clk) begin
        if (reset_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got id %0d data %h expected no response", rsp_id, rsp_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rsp_id", rsp_id, mon_exp[9:8]);
                check("rsp_data", rsp_data, mon_exp[7:0]);
`ifdef MSS_SCAN_PARITY_EN
                check("rsp_parity", rsp_parity, ^mon_exp[7:0]);
`endif
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '0;
        req_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        reset_n = 1'b1;

        // Test 1: first scan returns the empty chain, latency T+1..T+8 / T+9.
        step();
        set_req(2, 8'hA5);
        push_exp(2'd2, 8'h00);
        wait_accept("t1_grant_a", 2);
        req_valid[2] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("t1_enable_c%0d", k), mss_enable, 1);
            check($sformatf("t1_sel_c%0d", k), mss_cluster_sel, 2);
            check($sformatf("t1_rsp_valid_c%0d", k), rsp_valid, 0);
        end
        @(negedge clk);
        check("t1_enable_c9", mss_enable, 0);
        check("t1_rsp_valid_c9", rsp_valid, 1);
        step();
        set_req(2, 8'h3C);
        push_exp(2'd2, 8'hA5);
        wait_accept("t1_grant_b", 2);
        req_valid[2] = 1'b0;
        wait_idle("t1_idle");

        // Test 2: all requesters valid from a fresh pointer.
        do_reset();
        set_req(0, 8'h11);
        set_req(1, 8'h22);
        set_req(2, 8'h33);
        set_req(3, 8'h44);
        push_exp(2'd0, 8'h3C);
        push_exp(2'd1, 8'h11);
        push_exp(2'd2, 8'h22);
        push_exp(2'd3, 8'h33);
        push_exp(2'd0, 8'h44);
        wait_accept("t2_grant0", 0);
        wait_accept("t2_grant1", 1);
        wait_accept("t2_grant2", 2);
        wait_accept("t2_grant3", 3);
        wait_accept("t2_grant4", 0);
        req_valid = '0;
        wait_idle("t2_idle");

        // Test 3: response stall for five cycles with another requester waiting.
        step();
        rsp_ready = 1'b0;
        set_req(1, 8'h5A);
        push_exp(2'd1, 8'h11);
        wait_accept("t3_grant", 1);
        req_valid[1] = 1'b0;
        set_req(0, 8'h00);
        begin
            bit seen;
            seen = 1'b0;
            for (int n = 0; n < 50 && !seen; n++) begin
                @(negedge clk);
                if (rsp_valid) seen = 1'b1;
            end
            check("t3_rsp_arrives", seen, 1);
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("t3_hold_valid_%0d", i), rsp_valid, 1);
            check($sformatf("t3_hold_data_%0d", i), rsp_data, 8'h11);
            check($sformatf("t3_hold_id_%0d", i), rsp_id, 1);
            check($sformatf("t3_hold_ready_%0d", i), req_ready, 0);
            check($sformatf("t3_hold_enable_%0d", i), mss_enable, 0);
        end
        step();
        rsp_ready = 1'b1;
        step();
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("t3_back_idle", dbg_state, IDLE);
        check("t3_rsp_valid_low", rsp_valid, 0);

        // Test 4: sparse requests, a withdrawn request, then 0 and 2 together.
        step();
        set_req(3, 8'h0F);
        push_exp(2'd3, 8'h5A);
        wait_accept("t4_grant_3", 3);
        req_valid[3] = 1'b0;
        wait_idle("t4_idle_a");
        step();
        set_req(1, 8'hF0);
        push_exp(2'd1, 8'h0F);
        wait_accept("t4_grant_1", 1);
        req_valid[1] = 1'b0;
        wait_idle("t4_idle_b");
        step();
        req_valid[0] = 1'b1;
        #2;
        check("t4_glitch_grant", req_ready, 4'b0001);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("t4_glitch_busy", busy, 0);
        step();
        check("t4_glitch_state", dbg_state, IDLE);
        set_req(0, 8'h81);
        set_req(2, 8'h7E);
        push_exp(2'd2, 8'hF0);
        wait_accept("t4_grant_2", 2);
        req_valid = '0;
        wait_idle("t4_idle_c");

        // Test 5: reset in the 4th SHIFT cycle leaves three bits of C3 in the chain.
        step();
        set_req(3, 8'hC3);
        wait_accept("t5_grant_abort", 3);
        req_valid[3] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("t5_pre_enable", mss_enable, 1);
        check("t5_pre_sel", mss_cluster_sel, 3);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("t5_abort");
        step();
        reset_n = 1'b1;
        step();
        set_req(1, 8'h99);
        set_req(3, 8'h24);
        push_exp(2'd1, 8'hF6);
        push_exp(2'd3, 8'h99);
        wait_accept("t5_grant_1", 1);
        req_valid[1] = 1'b0;
        wait_accept("t5_grant_3", 3);
        req_valid[3] = 1'b0;
        wait_idle("t5_idle");

`ifdef MSS_SCAN_PARITY_EN
        // Test 6: a capture of 07 carries odd parity (A5 was covered in test 1).
        step();
        set_req(0, 8'h07);
        push_exp(2'd0, 8'h24);
        wait_accept("t6_grant_a", 0);
        req_valid[0] = 1'b0;
        wait_idle("t6_idle_a");
        step();
        set_req(1, 8'h00);
        push_exp(2'd1, 8'h07);
        wait_accept("t6_grant_b", 1);
        req_valid[1] = 1'b0;
        wait_idle("t6_idle_b");
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mss_scan_ctrl.md
Name: mss_scan_ctrl

Overview:
Scan-access controller for one mss_block scan chain, shared by NUM_REQ cluster requesters. It arbitrates requests round-robin and serially shifts the winner's pattern into the chain. It captures the bits shifted out, which are the chain's previous contents, and returns them on a valid/ready response channel. It sits between cluster-level test agents and the MSS, and is the only driver of the MSS enable, scan_in and cluster_sel inputs.

Parameters:
- CHAIN_LEN, 8: scan chain length in bits; also the pattern and response width.
- NUM_REQ, 4: number of requesters; ID_W = $clog2(NUM_REQ), 2 at default.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_data  in  NUM_REQ*CHAIN_LEN  patterns; requester i occupies bits [i*CHAIN_LEN +: CHAIN_LEN]
- req_ready  out  NUM_REQ  one-hot grant/accept
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_data  out  CHAIN_LEN  captured chain contents, MSB = first bit out
- rsp_id  out  ID_W  requester that owns the response
- busy  out  1  high in any state other than IDLE
- mss_enable  out  1  to mss_block enable
- mss_scan_in  out  1  to mss_block scan_in
- mss_cluster_sel  out  ID_W  to mss_block cluster_sel
- mss_scan_out  in  1  from mss_block scan_out

Behaviour:
- Reset is asynchronous and active-low on reset_n; clock is clk. Reset values:
  - state = IDLE, RR pointer = 0
  - req_ready = 0, rsp_valid = 0, rsp_data = 0, rsp_id = 0, busy = 0
  - mss_enable = 0, mss_scan_in = 0, mss_cluster_sel = 0
- FSM has three states: IDLE, SHIFT, RESP.
- IDLE:
  - req_ready is a combinational one-hot grant: the first asserted req_valid at or after the RR pointer, wrapping.
  - req_ready is 0 when no req_valid is asserted, and it is 0 in every state other than IDLE.
  - A request is accepted when req_valid[g] and req_ready[g] are both high at a clock edge.
  - On acceptance: load pattern shift register from req_data[g]; latch id = g; pointer = (g+1) mod NUM_REQ; bit counter = 0; go to SHIFT.
- SHIFT, lasting exactly CHAIN_LEN cycles:
  - mss_enable = 1.
  - mss_scan_in = pattern register MSB, so the pattern is sent MSB first.
  - Each edge: pattern shifts left; capture <= {capture[CHAIN_LEN-2:0], mss_scan_out}; counter increments.
  - At counter == CHAIN_LEN-1: go to RESP.
- RESP:
  - rsp_valid = 1; rsp_data = capture; rsp_id = latched id. All three are held stable until rsp_ready.
  - On the rsp_valid & rsp_ready edge: go to IDLE.
- mss_cluster_sel = latched id in SHIFT and RESP, and holds its last value in IDLE.
- All MSS-facing outputs decode from registers only; none depend combinationally on inputs.
- Latency: request accepted in cycle T → mss_enable high in cycles T+1..T+CHAIN_LEN → rsp_valid from cycle T+CHAIN_LEN+1.
  - The earliest next acceptance is the cycle after the response handshake.
- Post-shift chain content: after SHIFT the chain holds the accepted pattern exactly, so the next response to any requester returns it.
- Boundaries:
  - req_valid deasserted before a grant: nothing is accepted and the pointer is unchanged.
  - A requester may keep req_valid high across its own transaction; it is re-granted only in its RR turn.
  - rsp_ready asserted before RESP is ignored.
  - reset_n asserted mid-SHIFT or mid-RESP aborts immediately and returns all outputs to reset values. The chain then holds a partial pattern; software must rescan.

Optional Feature:
- Macro: MSS_SCAN_PARITY_EN.
- Defined: extra output rsp_parity (1 bit) = XOR of the captured bits. It is registered with rsp_data, valid with rsp_valid, and resets to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package mss_pkg holds:
  - state typedef (IDLE/SHIFT/RESP)
  - default CHAIN_LEN and NUM_REQ constants
  - ID_W function/constant
- One sub-module, mss_rr_arbiter (parameter NUM_REQ):
  - inputs: req vector, pointer
  - outputs: one-hot grant, encoded id
  - purely combinational; the pointer register lives in mss_scan_ctrl.

Test Plan:
1. After reset, requester 2 sends 8'hA5 with mss_block model attached → mss_enable high exactly 8 cycles, mss_cluster_sel = 2, rsp_data = 8'h00, rsp_id = 2, rsp_valid in cycle T+9. Requester 2 then sends 8'h3C → rsp_data = 8'hA5.
2. All four req_valid held high, rsp_ready always 1 → grant order 0,1,2,3,0. Each rsp_data equals the previous transaction's pattern.
3. Response stall: rsp_ready low for 5 cycles in RESP → rsp_valid/rsp_data/rsp_id stable, req_ready = 0, mss_enable = 0. Handshake on cycle 6 → IDLE next cycle.
4. Sparse requests: only requester 3 then requester 1 valid → grants 3 then 1, pointer 2 afterward. Next simultaneous 0 and 2 → 2 wins.
5. Reset asserted on the 4th SHIFT cycle → all outputs at reset values asynchronously. After release, requester 1 alone → granted, pointer behaviour from 0.
6. With MSS_SCAN_PARITY_EN, capture 8'hA5 → rsp_parity = 0; capture 8'h07 → rsp_parity = 1. Without the macro, the build has no rsp_parity port.
